// File: rtl/data_mem_bus_if.sv
// Core-side load/store port of the data memory subsystem.
// The core drives address, strobe and write lanes; the memory returns registered read data.
interface data_mem_bus_if;
    logic [31:0] memAddr;
    logic        memRStrb;
    logic [31:0] memRData;
    logic [31:0] memWData;
    logic [3:0]  memWMask;

    modport master (output memAddr, memRStrb, memWData, memWMask, input memRData);
    modport slave  (input memAddr, memRStrb, memWData, memWMask, output memRData);
endinterface

// File: rtl/data_mem_bus.sv
// Data RAM plus IO page (LED register, buffered 8N1 UART transmitter) behind the core's data port.
// Read data appears the cycle after the strobe and holds until the next strobe.
module data_mem_bus #(
    parameter int RAM_WORDS  = 16384,
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic          clk,
    input  logic          reset,
    data_mem_bus_if.slave bus,
    output logic [7:0]    leds,
    output logic          uartTx
);
    localparam int AW  = $clog2(RAM_WORDS);
    localparam int DIV = CLK_HZ / BAUD;
    localparam int BCW = $clog2(DIV);
    localparam int PW  = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} txState_t;

    // Only a subset of address bits decodes; the rest alias.
    wire unusedAddr = ^bus.memAddr;

    logic          isIo, wr;
    logic [1:0]    regSel;
    logic [AW-1:0] ramIdx;
    assign isIo   = bus.memAddr[22];
    assign regSel = bus.memAddr[3:2];
    assign ramIdx = bus.memAddr[AW+1:2];
    assign wr     = |bus.memWMask;

    // Data RAM: no reset, read-before-write on a same-word collision.
    logic [31:0] ram [RAM_WORDS];
    logic [31:0] ramQ;
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (wr && !isIo && bus.memWMask[i]) ram[ramIdx][8*i +: 8] <= bus.memWData[8*i +: 8];
        if (bus.memRStrb) ramQ <= ram[ramIdx];
    end

    // UART FIFO state
    logic [7:0]    fifoMem [FIFO_DEPTH];
    logic [PW-1:0] wrPtr, rdPtr;
    logic [3:0]    count;
    logic          overflow, full, empty, pushReq, pushOk, pop, busy;
    assign full    = (count == 4'(FIFO_DEPTH));
    assign empty   = (count == 4'd0);
    assign pushReq = wr && isIo && (regSel == 2'd1) && bus.memWMask[0];
    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign pushOk  = pushReq && (!full || pop);

    always_ff @(posedge clk) if (pushOk) fifoMem[wrPtr] <= bus.memWData[7:0];

    // TX FSM
    txState_t       state, stateN;
    logic [BCW-1:0] baudCnt, baudN;
    logic [7:0]     shiftReg, shiftN;
    logic [2:0]     bitCnt, bitN;
    logic           txN;
    assign busy = (state != IDLE);

    always_comb begin
        stateN = state;
        baudN  = baudCnt;
        shiftN = shiftReg;
        bitN   = bitCnt;
        txN    = uartTx;
        pop    = 1'b0;
        case (state)
            IDLE: if (!empty) begin
                pop    = 1'b1;
                shiftN = fifoMem[rdPtr];
                txN    = 1'b0;
                baudN  = BCW'(DIV - 1);
                stateN = START;
            end
            START: if (baudCnt == '0) begin
                stateN = DATA;
                txN    = shiftReg[0];
                shiftN = shiftReg >> 1;
                bitN   = 3'd0;
                baudN  = BCW'(DIV - 1);
            end else baudN = baudCnt - 1'b1;
            DATA: if (baudCnt == '0) begin
                baudN = BCW'(DIV - 1);
                if (bitCnt == 3'd7) begin
                    stateN = STOP;
                    txN    = 1'b1;
                end else begin
                    txN    = shiftReg[0];
                    shiftN = shiftReg >> 1;
                    bitN   = bitCnt + 3'd1;
                end
            end else baudN = baudCnt - 1'b1;
            STOP: if (baudCnt == '0) stateN = IDLE;
                  else baudN = baudCnt - 1'b1;
            default: stateN = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            baudCnt  <= '0;
            shiftReg <= '0;
            bitCnt   <= '0;
            uartTx   <= 1'b1;
        end else begin
            state    <= stateN;
            baudCnt  <= baudN;
            shiftReg <= shiftN;
            bitCnt   <= bitN;
            uartTx   <= txN;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            count    <= '0;
            overflow <= 1'b0;
            leds     <= '0;
        end else begin
            if (pushOk) wrPtr <= wrPtr + 1'b1;
            if (pop)    rdPtr <= rdPtr + 1'b1;
            case ({pushOk, pop})
                2'b10:   count <= count + 4'd1;
                2'b01:   count <= count - 4'd1;
                default: ;
            endcase
            if (wr && isIo && regSel == 2'd2) overflow <= 1'b0;
            else if (pushReq && !pushOk)      overflow <= 1'b1;
            if (wr && isIo && regSel == 2'd0 && bus.memWMask[0]) leds <= bus.memWData[7:0];
        end
    end

    // IO read mux, captured on the strobe so it lines up with the RAM read.
    logic [31:0] ioRd, ioQ;
    logic        rdValid, rdIo;
    always_comb begin
        ioRd = '0;
        case (regSel)
            2'd0:    ioRd = {24'b0, leds};
            2'd1:    ioRd = {31'b0, full};
            2'd2:    ioRd = {24'b0, count, overflow, empty, full, busy};
            default: ioRd = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdValid <= 1'b0;
            rdIo    <= 1'b0;
            ioQ     <= '0;
        end else if (bus.memRStrb) begin
            rdValid <= 1'b1;
            rdIo    <= isIo;
            ioQ     <= ioRd;
        end
    end

    // RAM has no reset, so gate it until the first strobe to give a clean zero.
    assign bus.memRData = !rdValid ? 32'h0 : (rdIo ? ioQ : ramQ);
endmodule

// File: tb/tb_data_mem_bus.sv
// Directed bench: table of bus vectors plus hand-written UART, FIFO and reset sequences.
module tb_data_mem_bus;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [7:0] leds;
    logic uartTx;
    always #5 clk = ~clk;

    data_mem_bus_if bus();
    data_mem_bus #(.RAM_WORDS(1024), .CLK_HZ(16), .BAUD(4), .FIFO_DEPTH(8)) dut (
        .clk(clk), .reset(reset), .bus(bus), .leds(leds), .uartTx(uartTx));

    localparam logic [31:0] A_LED = 32'h0040_0000, A_DAT = 32'h0040_0004,
                            A_STS = 32'h0040_0008, A_RSV = 32'h0040_000C;

    int tests = 0, fails = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One bus cycle: drive at a negedge, returns at the next negedge (the posedge in between applies it).
    task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m, input logic s);
        bus.memAddr = a; bus.memWData = d; bus.memWMask = m; bus.memRStrb = s;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(32'h0, 32'h0, 4'h0, 1'b0);
    endtask

    function automatic logic frameBit(input logic [7:0] b, input int j);
        if (j == 0) return 1'b0;
        if (j == 9) return 1'b1;
        return b[j-1];
    endfunction

    // Serial receiver sampling mid-bit (DIV=4)
    logic [7:0] rxq[$];
    logic [7:0] rxByte;
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && uartTx == 1'b0) begin
                repeat (2) @(negedge clk);
                for (int j = 0; j < 8; j++) begin
                    repeat (4) @(negedge clk);
                    rxByte[j] = uartTx;
                end
                repeat (4) @(negedge clk);
                if (uartTx) rxq.push_back(rxByte);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        logic        rstrb;
        logic [31:0] expR;
        logic [7:0]  expLeds;
    } vec_t;
    vec_t vecs[17];

    int p, busyCnt, n;
    logic [7:0] expRx[10];

    initial begin
        vecs[0]  = '{32'h0000_0100, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0000_0004, 8'h00};
        vecs[1]  = '{32'h0000_0100, 32'h0,         4'h0, 1'b1, 32'hDEAD_BEEF, 8'h00};
        vecs[2]  = '{32'h0000_0100, 32'h0000_00AA, 4'h1, 1'b0, 32'hDEAD_BEEF, 8'h00};
        vecs[3]  = '{32'h0000_0100, 32'h0,         4'h0, 1'b1, 32'hDEAD_BEAA, 8'h00};
        vecs[4]  = '{32'h0000_0100, 32'h1122_3344, 4'hF, 1'b1, 32'hDEAD_BEAA, 8'h00};
        vecs[5]  = '{32'h0000_0100, 32'h0,         4'h0, 1'b1, 32'h1122_3344, 8'h00};
        vecs[6]  = '{32'h0000_1100, 32'h0,         4'h0, 1'b1, 32'h1122_3344, 8'h00};
        vecs[7]  = '{32'h0000_0204, 32'h1234_5678, 4'hF, 1'b0, 32'h1122_3344, 8'h00};
        vecs[8]  = '{32'h0000_0204, 32'hAAAA_AAAA, 4'hA, 1'b0, 32'h1122_3344, 8'h00};
        vecs[9]  = '{32'h0080_0204, 32'h0,         4'h0, 1'b1, 32'hAA34_AA78, 8'h00};
        vecs[10] = '{A_LED,         32'h0000_005A, 4'h1, 1'b0, 32'hAA34_AA78, 8'h5A};
        vecs[11] = '{A_LED,         32'h0,         4'h0, 1'b1, 32'h0000_005A, 8'h5A};
        vecs[12] = '{A_LED,         32'h0000_00FF, 4'h0, 1'b0, 32'h0000_005A, 8'h5A};
        vecs[13] = '{A_LED,         32'h0000_FF00, 4'h2, 1'b0, 32'h0000_005A, 8'h5A};
        vecs[14] = '{A_RSV,         32'hFFFF_FFFF, 4'hF, 1'b0, 32'h0000_005A, 8'h5A};
        vecs[15] = '{A_RSV,         32'h0,         4'h0, 1'b1, 32'h0000_0000, 8'h5A};
        vecs[16] = '{A_DAT,         32'h0,         4'h0, 1'b1, 32'h0000_0000, 8'h5A};

        bus.memAddr = '0; bus.memWData = '0; bus.memWMask = '0; bus.memRStrb = 1'b0;
        repeat (2) @(negedge clk);
        check("reset rdata", bus.memRData, 32'h0);
        check("reset leds", {24'b0, leds}, 32'h0);
        check("reset uartTx", {31'b0, uartTx}, 32'h1);
        reset = 1'b0;
        drive(A_STS, 32'h0, 4'h0, 1'b1);
        check("reset status", bus.memRData, 32'h0000_0004);

        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].addr, vecs[i].wdata, vecs[i].mask, vecs[i].rstrb);
            check($sformatf("vec%0d rdata", i), bus.memRData, vecs[i].expR);
            check($sformatf("vec%0d leds", i), {24'b0, leds}, {24'b0, vecs[i].expLeds});
        end
        idle(2);

        // Single 0x55 frame, probed every cycle; status reads lag state by one cycle.
        drive(A_DAT, 32'h55, 4'h1, 1'b0);
        busyCnt = 0;
        for (int k = 0; k < 45; k++) begin
            drive(A_STS, 32'h0, 4'h0, 1'b1);
            check($sformatf("tx55 bit k=%0d", k), {31'b0, uartTx},
                  {31'b0, (k < 40) ? frameBit(8'h55, k / 4) : 1'b1});
            check($sformatf("tx55 busy k=%0d", k), {31'b0, bus.memRData[0]},
                  {31'b0, (k >= 1 && k <= 40)});
            busyCnt += int'(bus.memRData[0]);
        end
        check("tx55 busy cycles", busyCnt, 40);
        idle(4);
        check("tx55 rx count", rxq.size(), 1);
        if (rxq.size() > 0) check("tx55 rx byte", {24'b0, rxq[0]}, 32'h55);
        rxq.delete();

        // Overflow: 0x00 occupies the shifter, 0x01..0x08 fill the FIFO, 0x09 is dropped.
        p = cyc + 1;
        drive(A_DAT, 32'h00, 4'h1, 1'b0);
        for (int b = 1; b <= 9; b++) drive(A_DAT, b, 4'h1, 1'b0);
        drive(A_STS, 32'h0, 4'h0, 1'b1);
        check("ovf status", bus.memRData, 32'h0000_008B);
        drive(A_DAT, 32'h0, 4'h0, 1'b1);
        check("ovf data full", bus.memRData, 32'h1);
        drive(A_STS, 32'h0, 4'hF, 1'b0);
        drive(A_STS, 32'h0, 4'h0, 1'b1);
        check("ovf cleared", bus.memRData, 32'h0000_0083);
        // Push lands on the exact edge the FSM pops 0x01 out of the full FIFO.
        while (cyc + 1 < p + 42) idle(1);
        drive(A_DAT, 32'hA5, 4'h1, 1'b0);
        drive(A_STS, 32'h0, 4'h0, 1'b1);
        check("push on pop", bus.memRData, 32'h0000_0083);
        expRx[0] = 8'h00;
        for (int b = 1; b <= 8; b++) expRx[b] = 8'(b);
        expRx[9] = 8'hA5;
        n = 0;
        while (rxq.size() < 10 && n < 600) begin idle(1); n++; end
        check("fifo rx count", rxq.size(), 10);
        for (int b = 0; b < 10; b++)
            if (b < rxq.size()) check($sformatf("fifo rx %0d", b), {24'b0, rxq[b]}, {24'b0, expRx[b]});
        idle(10);

        // Reset in the middle of bit 3 of an 0xF0 frame with more bytes queued.
        drive(A_LED, 32'h77, 4'h1, 1'b0);
        drive(32'h100, 32'h0, 4'h0, 1'b1);
        p = cyc + 1;
        drive(A_DAT, 32'hF0, 4'h1, 1'b0);
        drive(A_DAT, 32'h11, 4'h1, 1'b0);
        drive(A_DAT, 32'h22, 4'h1, 1'b0);
        while (cyc < p + 18) idle(1);
        check("pre-reset bit3", {31'b0, uartTx}, 32'h0);
        check("pre-reset rdata", bus.memRData, 32'h1122_3344);
        reset = 1'b1;
        #1;
        check("mid reset uartTx", {31'b0, uartTx}, 32'h1);
        check("mid reset leds", {24'b0, leds}, 32'h0);
        check("mid reset rdata", bus.memRData, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        drive(A_STS, 32'h0, 4'h0, 1'b1);
        check("post reset status", bus.memRData, 32'h0000_0004);
        idle(50);
        rxq.delete();
        drive(A_DAT, 32'h3C, 4'h1, 1'b0);
        n = 0;
        while (rxq.size() < 1 && n < 100) begin idle(1); n++; end
        idle(60);
        check("post reset rx count", rxq.size(), 1);
        if (rxq.size() > 0) check("post reset rx byte", {24'b0, rxq[0]}, 32'h3C);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
